ahb_dbg_bus_arbiter: RTL and testbench
======================================

// Module: ahb_dbg_bus_arbiter
// PURPOSE
//  Two-master AHB arbiter. Shares the single AHB system bus between the core data master (M0)
//  and the debug-module system-bus-access master (M1).
//  It owns the HGRANT handshake, the address/data-phase muxing and HMASTER/HMASTLOCK generation.
//  It sits between both AHB master ports and the bus decoder/slaves.
// PARAMETERS
//  DEFAULT_MASTER  0   master parked on the bus (granted) when nobody requests
//  HOLD_MAX        16  cycles an owner may keep the grant while the other master requests (unlocked)
// PORTS
//  HCLK         in   1   bus clock
//  HRESETn      in   1   async active-low reset
//  HBUSREQ_M0/M1 in  1   bus request per master
//  HLOCK_M0/M1  in   1   locked-transfer request per master
//  HTRANS_M0/M1 in   2   transfer type per master
//  HADDR_M0/M1  in   `AHB_ADDR_WIDTH  address per master
//  HWRITE_M0/M1 in   1   direction per master
//  HSIZE_M0/M1  in   3   size per master
//  HBURST_M0/M1 in   3   burst per master
//  HPROT_M0/M1  in   4   protection per master
//  HWDATA_M0/M1 in   `AHB_DATA_WIDTH  write data per master
//  HGRANT_M0/M1 out  1   grant per master; one-hot, exactly one high at all times
//  HREADY       in   1   shared bus ready; also fed straight to both masters
//  HRESP        in   2   shared response
//  HTRANS,HADDR,HWRITE,HSIZE,HBURST,HPROT  out  as above  address-phase mux of owner
//  HWDATA       out  `AHB_DATA_WIDTH  data-phase mux of data owner
//  HMASTER      out  1   current address-phase owner
//  HMASTLOCK    out  1   owner's HLOCK, registered with the grant
// BEHAVIOUR
//  Clock/reset: single clock HCLK; HRESETn async, active-low.
//  Reset values:
//   - grant = DEFAULT_MASTER (HGRANT one-hot accordingly)
//   - HMASTER = data owner = DEFAULT_MASTER
//   - HMASTLOCK = 0, hold counter = 0
//   - muxed outputs follow the parked master
//  Owner FSM, states OWN_M0/OWN_M1. Updates only on an HREADY=1 cycle. An arbitration point is
//  HREADY=1 and owner HTRANS in {IDLE,NONSEQ}; never during SEQ/BUSY.
//   - owner HLOCK=1: stay.
//   - owner HBUSREQ=0 and other HBUSREQ=1: switch.
//   - both idle: move to DEFAULT_MASTER.
//   - both request: stay, unless hold counter == HOLD_MAX; then switch.
//  Priority when the FSM is not already fixed by the rules above: M1 (debug) over M0.
//  HGRANT is combinational from the owner state (registered state, glitch-free).
//  HMASTER follows the grant one cycle after the HREADY=1 edge that moved it, matching AHB
//  handover. A new owner drives its first address when HGRANT & HREADY are seen.
//  Address mux selects by HMASTER. Data owner <= HMASTER on every HREADY=1 edge.
//  HWDATA selects by data owner.
//  HREADY=0: grant, HMASTER and data owner all frozen. A stalled handover completes
//  correctly once HREADY rises.
//  Hold counter:
//   - increments while owner unlocked and other HBUSREQ=1; saturates at HOLD_MAX
//   - clears on switch, or when other HBUSREQ=0
//  HRESP ERROR: no arbiter action; the two-cycle response is passed through.
//  RETRY/SPLIT are unsupported and treated as OKAY for arbitration.
//  Reset mid-transfer: all state returns to reset values asynchronously; no pending grant
//  survives.
//  Both masters dropping HBUSREQ in the same cycle the other rises: the rules above apply
//  unchanged, evaluated on that cycle's inputs.
// CONFIGURATION
//  AHB_ARB_RR_EN defined: a contended arbitration point grants the master not served last
//  (1-bit round-robin pointer, reset to DEFAULT_MASTER). HOLD_MAX still bounds tenure.
//  Undefined: fixed priority M1 > M0 as above; no pointer register.
// STRUCTURE
//  Shared defines in top_defines.vh:
//   - `IDLE/`BUSY/`NONSEQ/`SEQ HTRANS encodings
//   - `AHB_ADDR_WIDTH/`AHB_DATA_WIDTH
//   - new `AHB_ARB_M0=1'b0, `AHB_ARB_M1=1'b1
//  One sub-module: ahb_arb_hold_timer (saturating tenure counter; clear/inc in, expired out).
// TESTING
//  1 Reset, no requests -> HGRANT_M0=1, HMASTER=0, HTRANS=IDLE; DEFAULT_MASTER=1 variant parks M1.
//  2 M0 owns, M1 raises HBUSREQ at NONSEQ with HREADY=1 -> HGRANT_M1=1 next cycle; HMASTER=1 one
//    cycle later; HWDATA switches one HREADY edge after that.
//  3 M0 INCR4 burst (NONSEQ,SEQ,SEQ,SEQ), M1 requests during the burst -> no switch until the
//    cycle after the 4th beat.
//  4 M0 HLOCK=1 for 40 cycles, M1 requesting -> grant never moves; HMASTLOCK=1; switch after lock
//    drops.
//  5 Both request continuously, unlocked single NONSEQs -> owner changes every 16 cycles
//    (HOLD_MAX); with AHB_ARB_RR_EN alternates at each contended point.
//  6 HREADY held 0 for 5 cycles during handover, then HRESETn pulsed low mid-stall -> grant/HMASTER
//    frozen during stall; reset restores DEFAULT_MASTER immediately.

Source files
------------

// File: rtl/ahb_dbg_bus_arbiter_pkg.sv
// Shared AHB encodings (top_defines.vh set) plus arbiter types and helpers.
// Optional round-robin arbitration is enabled with the AHB_ARB_RR_EN macro.
`ifndef TOP_DEFINES_VH
`define TOP_DEFINES_VH
`define IDLE           2'b00
`define BUSY           2'b01
`define NONSEQ         2'b10
`define SEQ            2'b11
`define AHB_ADDR_WIDTH 32
`define AHB_DATA_WIDTH 32
`define AHB_ARB_M0     1'b0
`define AHB_ARB_M1     1'b1
`endif

package ahb_dbg_bus_arbiter_pkg;

    localparam int AW = `AHB_ADDR_WIDTH;
    localparam int DW = `AHB_DATA_WIDTH;

    localparam logic [0:0] OWN_M0 = `AHB_ARB_M0;
    localparam logic [0:0] OWN_M1 = `AHB_ARB_M1;

    typedef struct packed {
        logic [1:0]    htrans;
        logic [AW-1:0] haddr;
        logic          hwrite;
        logic [2:0]    hsize;
        logic [2:0]    hburst;
        logic [3:0]    hprot;
    } ahb_addr_t;

    // The bus may only change hands between bursts, never inside SEQ/BUSY.
    function automatic logic is_arb_point(input logic [1:0] htrans);
        return (htrans == `IDLE) || (htrans == `NONSEQ);
    endfunction

endpackage

// File: rtl/ahb_dbg_bus_arbiter_if.sv
// Two-master AHB arbiter bundle: per-master request/address/data, shared response and muxed bus.
interface ahb_dbg_bus_arbiter_if;
    import ahb_dbg_bus_arbiter_pkg::*;

    logic          HBUSREQ_M0, HBUSREQ_M1;
    logic          HLOCK_M0,   HLOCK_M1;
    logic [1:0]    HTRANS_M0,  HTRANS_M1;
    logic [AW-1:0] HADDR_M0,   HADDR_M1;
    logic          HWRITE_M0,  HWRITE_M1;
    logic [2:0]    HSIZE_M0,   HSIZE_M1;
    logic [2:0]    HBURST_M0,  HBURST_M1;
    logic [3:0]    HPROT_M0,   HPROT_M1;
    logic [DW-1:0] HWDATA_M0,  HWDATA_M1;
    logic          HGRANT_M0,  HGRANT_M1;

    logic          HREADY;
    logic [1:0]    HRESP;

    logic [1:0]    HTRANS;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic [DW-1:0] HWDATA;
    logic          HMASTER;
    logic          HMASTLOCK;

    modport slave (
        input  HBUSREQ_M0, HBUSREQ_M1, HLOCK_M0, HLOCK_M1,
               HTRANS_M0, HTRANS_M1, HADDR_M0, HADDR_M1,
               HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1,
               HBURST_M0, HBURST_M1, HPROT_M0, HPROT_M1,
               HWDATA_M0, HWDATA_M1, HREADY, HRESP,
        output HGRANT_M0, HGRANT_M1, HTRANS, HADDR, HWRITE, HSIZE,
               HBURST, HPROT, HWDATA, HMASTER, HMASTLOCK
    );

    modport master (
        output HBUSREQ_M0, HBUSREQ_M1, HLOCK_M0, HLOCK_M1,
               HTRANS_M0, HTRANS_M1, HADDR_M0, HADDR_M1,
               HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1,
               HBURST_M0, HBURST_M1, HPROT_M0, HPROT_M1,
               HWDATA_M0, HWDATA_M1,
        input  HGRANT_M0, HGRANT_M1, HREADY, HRESP, HMASTER, HMASTLOCK
    );

endinterface

// File: rtl/ahb_arb_hold_timer.sv
// Saturating tenure counter; expired flags the cycle whose count reaches HOLD_MAX.
module ahb_arb_hold_timer #(
    parameter int HOLD_MAX = 16
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_nxt;

    assign cnt_nxt = (cnt_q == CW'(HOLD_MAX)) ? cnt_q : cnt_q + 1'b1;
    // Counts the current contended cycle, so tenure under contention is exactly HOLD_MAX cycles.
    assign expired = inc && (cnt_nxt == CW'(HOLD_MAX));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)   cnt_q <= '0;
        else if (clr)   cnt_q <= '0;
        else if (inc)   cnt_q <= cnt_nxt;
    end

endmodule

// File: rtl/ahb_dbg_bus_arbiter.sv
// Two-master AHB arbiter (core M0, debug SBA M1): grant FSM, HMASTER/data-owner tracking, bus muxes.
// Define AHB_ARB_RR_EN for round-robin on contended arbitration points.
module ahb_dbg_bus_arbiter
    import ahb_dbg_bus_arbiter_pkg::*;
#(
    parameter logic DEFAULT_MASTER = `AHB_ARB_M0,
    parameter int   HOLD_MAX       = 16
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb_dbg_bus_arbiter_if.slave bus
);
    logic      own_q, own_d, hmaster_q, downer_q, mastlock_q;
    logic      own_lock, own_req, oth_req, arb_pt, contend_win;
    logic      hold_exp, hold_clr, hold_inc;
    logic      resp_unused;
    ahb_addr_t a_m0, a_m1, a_sel;

    assign a_m0 = '{bus.HTRANS_M0, bus.HADDR_M0, bus.HWRITE_M0, bus.HSIZE_M0, bus.HBURST_M0, bus.HPROT_M0};
    assign a_m1 = '{bus.HTRANS_M1, bus.HADDR_M1, bus.HWRITE_M1, bus.HSIZE_M1, bus.HBURST_M1, bus.HPROT_M1};
    assign a_sel = (hmaster_q == OWN_M1) ? a_m1 : a_m0;

    assign own_lock = (own_q == OWN_M1) ? bus.HLOCK_M1   : bus.HLOCK_M0;
    assign own_req  = (own_q == OWN_M1) ? bus.HBUSREQ_M1 : bus.HBUSREQ_M0;
    assign oth_req  = (own_q == OWN_M1) ? bus.HBUSREQ_M0 : bus.HBUSREQ_M1;
    // Arbitration tracks the transfer currently on the bus, i.e. the address-phase owner's HTRANS.
    assign arb_pt   = bus.HREADY && is_arb_point(a_sel.htrans);

`ifdef AHB_ARB_RR_EN
    logic rr_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)                        rr_q <= DEFAULT_MASTER;
        else if (arb_pt && (own_req || oth_req)) rr_q <= own_d;
    end
    assign contend_win = hold_exp ? ~own_q : ~rr_q;
`else
    assign contend_win = hold_exp ? ~own_q : own_q;
`endif

    always_comb begin
        own_d = own_q;
        if (arb_pt && !own_lock) begin
            if (!own_req && oth_req)       own_d = ~own_q;
            else if (!own_req && !oth_req) own_d = DEFAULT_MASTER;
            else if (own_req && oth_req)   own_d = contend_win;
        end
    end

    assign hold_inc = !own_lock && oth_req;
    assign hold_clr = (own_d != own_q) || !oth_req;

    ahb_arb_hold_timer #(.HOLD_MAX(HOLD_MAX)) u_hold (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clr     (hold_clr),
        .inc     (hold_inc),
        .expired (hold_exp)
    );

    // Grant, address owner and data owner form a one-edge-per-stage pipeline, frozen by HREADY=0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            own_q      <= DEFAULT_MASTER;
            hmaster_q  <= DEFAULT_MASTER;
            downer_q   <= DEFAULT_MASTER;
            mastlock_q <= 1'b0;
        end else if (bus.HREADY) begin
            own_q      <= own_d;
            hmaster_q  <= own_q;
            downer_q   <= hmaster_q;
            mastlock_q <= own_lock;
        end
    end

    assign bus.HGRANT_M0 = (own_q == OWN_M0);
    assign bus.HGRANT_M1 = (own_q == OWN_M1);
    assign bus.HTRANS    = a_sel.htrans;
    assign bus.HADDR     = a_sel.haddr;
    assign bus.HWRITE    = a_sel.hwrite;
    assign bus.HSIZE     = a_sel.hsize;
    assign bus.HBURST    = a_sel.hburst;
    assign bus.HPROT     = a_sel.hprot;
    assign bus.HWDATA    = (downer_q == OWN_M1) ? bus.HWDATA_M1 : bus.HWDATA_M0;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = mastlock_q;

    // Responses (including two-cycle ERROR) go slave-to-master directly; arbitration ignores them.
    assign resp_unused = ^bus.HRESP;

endmodule

// File: tb/tb_ahb_dbg_bus_arbiter.sv
// Directed bench for ahb_dbg_bus_arbiter: parking, handover timing, bursts, lock, hold limit, stall/reset.
module tb_ahb_dbg_bus_arbiter;

    localparam logic [31:0] A0 = 32'h1000_0000, A1 = 32'h2000_0000;
    localparam logic [31:0] D0 = 32'hAAAA_0000, D1 = 32'hBBBB_0000;
    localparam logic [1:0]  T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
`ifdef AHB_ARB_RR_EN
    localparam int PERIOD = 1;
`else
    localparam int PERIOD = 16;
`endif

    logic HCLK = 1'b0;
    logic HRESETn;
    int   n_cmp = 0, n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_dbg_bus_arbiter_if bus();
    ahb_dbg_bus_arbiter_if bus1();

    ahb_dbg_bus_arbiter #(.DEFAULT_MASTER(1'b0), .HOLD_MAX(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));
    ahb_dbg_bus_arbiter #(.DEFAULT_MASTER(1'b1), .HOLD_MAX(16)) dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int chg[$];
        int bad;
        logic prev;

        HRESETn = 1'b0;
        bus.HBUSREQ_M0 = 0; bus.HBUSREQ_M1 = 0; bus.HLOCK_M0 = 0; bus.HLOCK_M1 = 0;
        bus.HTRANS_M0 = T_IDLE; bus.HTRANS_M1 = T_IDLE;
        bus.HADDR_M0 = A0; bus.HADDR_M1 = A1; bus.HWDATA_M0 = D0; bus.HWDATA_M1 = D1;
        bus.HWRITE_M0 = 1; bus.HWRITE_M1 = 0; bus.HSIZE_M0 = 3'd2; bus.HSIZE_M1 = 3'd2;
        bus.HBURST_M0 = 3'd0; bus.HBURST_M1 = 3'd0; bus.HPROT_M0 = 4'h3; bus.HPROT_M1 = 4'h1;
        bus.HREADY = 1; bus.HRESP = 2'b00;
        bus1.HBUSREQ_M0 = 0; bus1.HBUSREQ_M1 = 0; bus1.HLOCK_M0 = 0; bus1.HLOCK_M1 = 0;
        bus1.HTRANS_M0 = T_IDLE; bus1.HTRANS_M1 = T_IDLE;
        bus1.HADDR_M0 = A0; bus1.HADDR_M1 = A1; bus1.HWDATA_M0 = D0; bus1.HWDATA_M1 = D1;
        bus1.HWRITE_M0 = 0; bus1.HWRITE_M1 = 0; bus1.HSIZE_M0 = 0; bus1.HSIZE_M1 = 0;
        bus1.HBURST_M0 = 0; bus1.HBURST_M1 = 0; bus1.HPROT_M0 = 0; bus1.HPROT_M1 = 0;
        bus1.HREADY = 1; bus1.HRESP = 2'b00;

        // 1: reset / parking
        #12;
        chk("rst_gnt0", bus.HGRANT_M0, 1);
        chk("rst_gnt1", bus.HGRANT_M1, 0);
        chk("rst_hmaster", bus.HMASTER, 0);
        chk("rst_htrans", bus.HTRANS, T_IDLE);
        chk("rst_mastlock", bus.HMASTLOCK, 0);
        chk("rst_haddr", bus.HADDR, A0);
        chk("rst_hwdata", bus.HWDATA, D0);
        chk("rst1_gnt1", bus1.HGRANT_M1, 1);
        chk("rst1_hmaster", bus1.HMASTER, 1);
        chk("rst1_haddr", bus1.HADDR, A1);
        @(negedge HCLK); HRESETn = 1'b1;
        step();
        chk("park_gnt0", bus.HGRANT_M0, 1);
        chk("park1_gnt1", bus1.HGRANT_M1, 1);

        // 2: handover M0 -> M1
        bus.HTRANS_M0 = T_NONSEQ; bus.HBUSREQ_M1 = 1;
        step();
        chk("ho_gnt1", bus.HGRANT_M1, 1);
        chk("ho_gnt0", bus.HGRANT_M0, 0);
        chk("ho_hmaster0", bus.HMASTER, 0);
        bus.HTRANS_M0 = T_IDLE; bus.HTRANS_M1 = T_NONSEQ;
        step();
        chk("ho_hmaster1", bus.HMASTER, 1);
        chk("ho_haddr", bus.HADDR, A1);
        chk("ho_htrans", bus.HTRANS, T_NONSEQ);
        chk("ho_hwdata_old", bus.HWDATA, D0);
        step();
        chk("ho_hwdata_new", bus.HWDATA, D1);

        // back to M0
        bus.HBUSREQ_M1 = 0; bus.HTRANS_M1 = T_IDLE; bus.HBUSREQ_M0 = 1;
        step();
        chk("back_gnt0", bus.HGRANT_M0, 1);
        step();
        chk("back_hmaster", bus.HMASTER, 0);

        // 3: INCR4 burst must not be broken
        bus.HTRANS_M0 = T_NONSEQ; bus.HBURST_M0 = 3'b011;
        step();
        bus.HTRANS_M0 = T_SEQ; bus.HBUSREQ_M0 = 0; bus.HBUSREQ_M1 = 1;
        step(); chk("burst_b2", bus.HGRANT_M0, 1);
        step(); chk("burst_b3", bus.HGRANT_M0, 1);
        step(); chk("burst_b4", bus.HGRANT_M0, 1);
        bus.HTRANS_M0 = T_IDLE; bus.HBURST_M0 = 3'b000;
        step(); chk("burst_after", bus.HGRANT_M1, 1);
        bus.HTRANS_M1 = T_NONSEQ;

        // 4: locked M0 holds against M1 for 40 cycles
        bus.HBUSREQ_M1 = 0; bus.HTRANS_M1 = T_IDLE;
        bus.HBUSREQ_M0 = 1; bus.HLOCK_M0 = 1; bus.HTRANS_M0 = T_NONSEQ;
        step();
        chk("lock_gnt0", bus.HGRANT_M0, 1);
        bus.HBUSREQ_M1 = 1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.HGRANT_M0 !== 1'b1) bad++;
        end
        chk("lock_moves", bad, 0);
        chk("lock_mastlock", bus.HMASTLOCK, 1);
        chk("lock_hmaster", bus.HMASTER, 0);
        bus.HLOCK_M0 = 0; bus.HBUSREQ_M0 = 0;
        step();
        chk("unlock_gnt1", bus.HGRANT_M1, 1);
        chk("unlock_mastlock", bus.HMASTLOCK, 0);

        // 5: continuous contention, hold limit / round-robin
        bus.HBUSREQ_M0 = 1; bus.HTRANS_M1 = T_NONSEQ;
        prev = bus.HGRANT_M1;
        bad = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (bus.HGRANT_M0 === bus.HGRANT_M1) bad++;
            if (bus.HGRANT_M1 !== prev) chg.push_back(i);
            prev = bus.HGRANT_M1;
        end
        chk("hold_onehot", bad, 0);
        chk("hold_nchg", (chg.size() >= 3), 1);
        if (chg.size() >= 3) begin
            chk("hold_first", chg[0], PERIOD);
            chk("hold_per1", chg[1] - chg[0], PERIOD);
            chk("hold_per2", chg[2] - chg[1], PERIOD);
        end

        // 6: stalled handover, then reset mid-stall
        bus.HBUSREQ_M0 = 0; bus.HBUSREQ_M1 = 0; bus.HTRANS_M0 = T_IDLE; bus.HTRANS_M1 = T_IDLE;
        step(); step();
        chk("idle_park", bus.HGRANT_M0, 1);
        bus.HTRANS_M0 = T_NONSEQ; bus.HBUSREQ_M1 = 1;
        step();
        chk("stall_pre_gnt1", bus.HGRANT_M1, 1);
        bus.HREADY = 0; bus.HTRANS_M0 = T_IDLE; bus.HTRANS_M1 = T_NONSEQ;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.HGRANT_M1 !== 1'b1 || bus.HMASTER !== 1'b0) bad++;
        end
        chk("stall_frozen", bad, 0);
        bus.HREADY = 1;
        step();
        chk("stall_done_hmaster", bus.HMASTER, 1);
        chk("stall_done_hwdata", bus.HWDATA, D0);
        bus.HREADY = 0;
        step(); step();
        HRESETn = 1'b0;
        #1;
        chk("mrst_gnt0", bus.HGRANT_M0, 1);
        chk("mrst_hmaster", bus.HMASTER, 0);
        chk("mrst_hwdata", bus.HWDATA, D0);
        chk("mrst1_gnt1", bus1.HGRANT_M1, 1);
        @(negedge HCLK); HRESETn = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
